fp_norm_lzc_pipe: RTL and testbench

// Normalization front-end for the FP add/sub datapath. Takes the un-normalized

---
 rtl/fp_norm_lzc_pipe.sv | 164 ++++++++++++++++
 tb/tb_fp_norm_lzc_pipe.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_norm_lzc_pipe.sv
// -----------------------------------------------------------------------------
// fp_norm_lzc_pipe
// Normalization front-end for the FP add/sub datapath. Counts the leading zeros
// of the un-normalized mantissa and produces a registered left-shift amount and
// adjusted exponent for the downstream barrel shifter. Subnormal results clamp
// the shift so the exponent never goes below zero.
// Two-stage valid/ready pipeline (capture, compute) with full backpressure and
// one-item-per-cycle throughput.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready       upstream handshake
//   i_mant, i_exp, i_sign   un-normalized mantissa, biased exponent, sign
//   o_valid / i_ready       downstream handshake
//   o_data                  captured mantissa, unshifted
//   o_shift_number          left-shift amount for the shifter
//   o_exp                   exponent after normalization
//   o_sign                  captured sign
//   o_zero                  mantissa was all zeros
//   o_denorm                result is subnormal
// -----------------------------------------------------------------------------
module fp_norm_lzc_pipe #(
    parameter int SIZE_DATA  = 24,
    parameter int SIZE_SHIFT = 5,
    parameter int SIZE_EXP   = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [SIZE_DATA-1:0]  i_mant,
    input  logic [SIZE_EXP-1:0]   i_exp,
    input  logic                  i_sign,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [SIZE_DATA-1:0]  o_data,
    output logic [SIZE_SHIFT-1:0] o_shift_number,
    output logic [SIZE_EXP-1:0]   o_exp,
    output logic                  o_sign,
    output logic                  o_zero,
    output logic                  o_denorm
);

    // Leading-zero count spans 0..SIZE_DATA inclusive.
    localparam int LZ_W  = $clog2(SIZE_DATA + 1);
    localparam int CMP_W = ((SIZE_EXP > LZ_W) ? SIZE_EXP : LZ_W) + 1;

    typedef struct packed {
        logic [SIZE_SHIFT-1:0] shift;
        logic [SIZE_EXP-1:0]   exp;
        logic                  zero;
        logic                  denorm;
    } norm_t;

    function automatic logic [LZ_W-1:0] f_lzc(input logic [SIZE_DATA-1:0] mant);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = SIZE_DATA - 1; i >= 0; i--) begin
            if (!found) begin
                if (mant[i]) found = 1'b1;
                else         n = n + 1'b1;
            end
        end
        return n;
    endfunction

    // Exponent/shift selection. The signed difference exp-lz decides between a
    // full normalization (diff > 0) and gradual underflow, where the shift is
    // clamped to exp-1 so the shifted value lands exactly on exponent 0.
    function automatic norm_t f_norm(input logic [SIZE_DATA-1:0] mant,
                                     input logic [SIZE_EXP-1:0]  exp);
        norm_t                 r;
        logic [LZ_W-1:0]       lz;
        logic signed [CMP_W:0] diff;
        lz   = f_lzc(mant);
        diff = $signed({1'b0, CMP_W'(exp)}) - $signed({1'b0, CMP_W'(lz)});
        r    = '0;
        if (mant == '0) begin
            r.zero = 1'b1;
        end else if (exp == '0) begin
            r.denorm = 1'b1;
        end else if (diff <= 0) begin
            r.shift  = SIZE_SHIFT'(exp - 1'b1);
            r.denorm = 1'b1;
        end else begin
            r.shift = SIZE_SHIFT'(lz);
            r.exp   = SIZE_EXP'(diff);
        end
        return r;
    endfunction

    logic                  r_vld_p1;
    logic [SIZE_DATA-1:0]  r_mant_p1;
    logic [SIZE_EXP-1:0]   r_exp_p1;
    logic                  r_sign_p1;

    logic                  r_vld_p2;
    logic [SIZE_DATA-1:0]  r_mant_p2;
    logic [SIZE_SHIFT-1:0] r_shift_p2;
    logic [SIZE_EXP-1:0]   r_exp_p2;
    logic                  r_sign_p2;
    logic                  r_zero_p2;
    logic                  r_denorm_p2;

    logic                  w_s2_adv;
    logic                  w_s1_adv;
    norm_t                 w_norm_p1;

    assign w_s2_adv  = !r_vld_p2 || i_ready;
    assign w_s1_adv  = !r_vld_p1 || w_s2_adv;
    assign o_ready   = w_s1_adv;
    assign w_norm_p1 = f_norm(r_mant_p1, r_exp_p1);

    // ---- Stage 1: capture ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p1  <= 1'b0;
            r_mant_p1 <= '0;
            r_exp_p1  <= '0;
            r_sign_p1 <= 1'b0;
        end else if (w_s1_adv) begin
            r_vld_p1 <= i_valid;
            if (i_valid) begin
                r_mant_p1 <= i_mant;
                r_exp_p1  <= i_exp;
                r_sign_p1 <= i_sign;
            end
        end
    end

    // ---- Stage 2: leading-zero count and normalization ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p2    <= 1'b0;
            r_mant_p2   <= '0;
            r_shift_p2  <= '0;
            r_exp_p2    <= '0;
            r_sign_p2   <= 1'b0;
            r_zero_p2   <= 1'b0;
            r_denorm_p2 <= 1'b0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_mant_p2   <= r_mant_p1;
                r_shift_p2  <= w_norm_p1.shift;
                r_exp_p2    <= w_norm_p1.exp;
                r_sign_p2   <= r_sign_p1;
                r_zero_p2   <= w_norm_p1.zero;
                r_denorm_p2 <= w_norm_p1.denorm;
            end
        end
    end

    assign o_valid        = r_vld_p2;
    assign o_data         = r_mant_p2;
    assign o_shift_number = r_shift_p2;
    assign o_exp          = r_exp_p2;
    assign o_sign         = r_sign_p2;
    assign o_zero         = r_zero_p2;
    assign o_denorm       = r_denorm_p2;

endmodule

// File: tb/tb_fp_norm_lzc_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_norm_lzc_pipe
// Self-checking bench for fp_norm_lzc_pipe: directed vector table, back-to-back
// stream under a fixed stall pattern, mid-flight asynchronous reset, and a
// randomized stream against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fp_norm_lzc_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [23:0] i_mant;
    logic [7:0]  i_exp;
    logic        i_sign;
    logic        o_valid;
    logic        i_ready;
    logic [23:0] o_data;
    logic [4:0]  o_shift_number;
    logic [7:0]  o_exp;
    logic        o_sign;
    logic        o_zero;
    logic        o_denorm;

    fp_norm_lzc_pipe #(.SIZE_DATA(24), .SIZE_SHIFT(5), .SIZE_EXP(8)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .i_mant         (i_mant),
        .i_exp          (i_exp),
        .i_sign         (i_sign),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_data         (o_data),
        .o_shift_number (o_shift_number),
        .o_exp          (o_exp),
        .o_sign         (o_sign),
        .o_zero         (o_zero),
        .o_denorm       (o_denorm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic        sign;
        int          acc_cyc;
    } item_t;

    typedef struct {
        logic [4:0] shift;
        logic [7:0] exp;
        logic       zero;
        logic       denorm;
    } res_t;

    typedef struct {
        logic [23:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic [4:0]  x_shift;
        logic [7:0]  x_exp;
        logic        x_zero;
        logic        x_denorm;
    } vec_t;

    item_t q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    cyc    = 0;
    int    n_out  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: count leading zeros with plain integer arithmetic, then pick
    // the case by comparing the biased exponent against that count.
    function automatic res_t model(input logic [23:0] m, input logic [7:0] e);
        res_t r;
        int   lz;
        int   ei;
        r  = '{5'd0, 8'd0, 1'b0, 1'b0};
        ei = int'(e);
        lz = 24;
        for (int b = 23; b >= 0; b--) begin
            if (m[b]) begin
                lz = 23 - b;
                break;
            end
        end
        if (m == 24'd0)      r.zero = 1'b1;
        else if (ei == 0)    r.denorm = 1'b1;
        else if (ei <= lz) begin
            r.shift  = 5'(ei - 1);
            r.denorm = 1'b1;
        end else begin
            r.shift = 5'(lz);
            r.exp   = 8'(ei - lz);
        end
        return r;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_valid"},  32'(o_valid), 32'd0);
        chk({tag, "_data"},   32'(o_data), 32'd0);
        chk({tag, "_shift"},  32'(o_shift_number), 32'd0);
        chk({tag, "_exp"},    32'(o_exp), 32'd0);
        chk({tag, "_sign"},   32'(o_sign), 32'd0);
        chk({tag, "_zero"},   32'(o_zero), 32'd0);
        chk({tag, "_denorm"}, 32'(o_denorm), 32'd0);
    endtask

    // One clock cycle: drive at negedge, check against the scoreboard, then
    // let the rising edge transfer and update the model queue.
    task automatic step(input logic iv, input logic [23:0] m, input logic [7:0] e,
                        input logic s, input logic rdy, output logic acc);
        logic cons;
        res_t r;
        @(negedge clk);
        i_valid = iv;
        i_mant  = m;
        i_exp   = e;
        i_sign  = s;
        i_ready = rdy;
        #1;
        chk("o_valid", 32'(o_valid),
            32'((q.size() > 0) && (cyc - q[0].acc_cyc >= 2)));
        chk("o_ready", 32'(o_ready), 32'(!(q.size() >= 2 && !rdy)));
        if (o_valid && q.size() > 0) begin
            r = model(q[0].mant, q[0].exp);
            chk("sb_data",   32'(o_data), 32'(q[0].mant));
            chk("sb_shift",  32'(o_shift_number), 32'(r.shift));
            chk("sb_exp",    32'(o_exp), 32'(r.exp));
            chk("sb_sign",   32'(o_sign), 32'(q[0].sign));
            chk("sb_zero",   32'(o_zero), 32'(r.zero));
            chk("sb_denorm", 32'(o_denorm), 32'(r.denorm));
        end
        acc  = iv && o_ready;
        cons = o_valid && rdy;
        @(posedge clk);
        if (cons && q.size() > 0) begin
            void'(q.pop_front());
            n_out++;
        end
        if (acc) q.push_back('{m, e, s, cyc});
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[11];
        logic        acc;
        logic [23:0] items[8];
        logic        pat[4];
        int          k;
        int          budget;
        int          out0;

        vecs[0]  = '{24'h800000, 8'd127, 1'b0, 5'd0,  8'd127, 1'b0, 1'b0};
        vecs[1]  = '{24'h000400, 8'd100, 1'b0, 5'd13, 8'd87,  1'b0, 1'b0};
        vecs[2]  = '{24'h000001, 8'd5,   1'b0, 5'd4,  8'd0,   1'b0, 1'b1};
        vecs[3]  = '{24'h000001, 8'd0,   1'b1, 5'd0,  8'd0,   1'b0, 1'b1};
        vecs[4]  = '{24'h000000, 8'd90,  1'b1, 5'd0,  8'd0,   1'b1, 1'b0};
        vecs[5]  = '{24'h400000, 8'd1,   1'b0, 5'd0,  8'd0,   1'b0, 1'b1};
        vecs[6]  = '{24'h400000, 8'd2,   1'b1, 5'd1,  8'd1,   1'b0, 1'b0};
        vecs[7]  = '{24'hFFFFFF, 8'd255, 1'b1, 5'd0,  8'd255, 1'b0, 1'b0};
        vecs[8]  = '{24'h000001, 8'd24,  1'b0, 5'd23, 8'd1,   1'b0, 1'b0};
        vecs[9]  = '{24'h000001, 8'd23,  1'b0, 5'd22, 8'd0,   1'b0, 1'b1};
        vecs[10] = '{24'h000000, 8'd0,   1'b0, 5'd0,  8'd0,   1'b1, 1'b0};

        // Reset state
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_mant  = '0;
        i_exp   = '0;
        i_sign  = 1'b0;
        i_ready = 1'b1;
        #1;
        check_outputs_zero("rst");
        chk("rst_ready", 32'(o_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table: one item at a time, exact 2-cycle latency
        for (int v = 0; v < 11; v++) begin
            step(1'b1, vecs[v].mant, vecs[v].exp, vecs[v].sign, 1'b1, acc);
            chk("tbl_accept", 32'(acc), 32'd1);
            step(1'b0, 24'd0, 8'd0, 1'b0, 1'b1, acc);
            #1;
            chk("tbl_valid",  32'(o_valid), 32'd1);
            chk("tbl_data",   32'(o_data), 32'(vecs[v].mant));
            chk("tbl_shift",  32'(o_shift_number), 32'(vecs[v].x_shift));
            chk("tbl_exp",    32'(o_exp), 32'(vecs[v].x_exp));
            chk("tbl_sign",   32'(o_sign), 32'(vecs[v].sign));
            chk("tbl_zero",   32'(o_zero), 32'(vecs[v].x_zero));
            chk("tbl_denorm", 32'(o_denorm), 32'(vecs[v].x_denorm));
        end
        step(1'b0, 24'd0, 8'd0, 1'b0, 1'b1, acc);
        chk("tbl_drained", 32'(q.size()), 32'd0);

        // Back-to-back stream with i_ready = 1,0,0,1,...
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        for (int i = 0; i < 8; i++) items[i] = 24'h000100 << i;
        out0   = n_out;
        k      = 0;
        budget = 0;
        while ((k < 8 || q.size() > 0) && budget < 100) begin
            if (k < 8) step(1'b1, items[k], 8'(20 + k), k[0], pat[budget % 4], acc);
            else       step(1'b0, 24'd0, 8'd0, 1'b0, pat[budget % 4], acc);
            if (acc) k++;
            budget++;
        end
        chk("b2b_all_out", 32'(n_out - out0), 32'd8);

        // Async reset with both stages full
        step(1'b1, 24'h123456, 8'd50, 1'b1, 1'b0, acc);
        step(1'b1, 24'h00ABCD, 8'd60, 1'b1, 1'b0, acc);
        step(1'b0, 24'd0, 8'd0, 1'b0, 1'b0, acc);
        chk("full_ready_low", 32'(o_ready), 32'd0);
        #2;
        i_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        check_outputs_zero("arst");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_ready", 32'(o_ready), 32'd1);
        step(1'b1, 24'h000400, 8'd100, 1'b0, 1'b1, acc);
        chk("post_rst_accept", 32'(acc), 32'd1);
        step(1'b0, 24'd0, 8'd0, 1'b0, 1'b1, acc);
        step(1'b0, 24'd0, 8'd0, 1'b0, 1'b1, acc);

        // Randomized stream against the model
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rv;
            logic [23:0] m;
            logic [7:0]  e;
            rv = $urandom;
            m  = 24'(rv >> $urandom_range(0, 26));
            if ($urandom_range(0, 15) == 0) m = 24'd0;
            e  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 30))
                                              : 8'($urandom_range(0, 255));
            step($urandom_range(0, 3) != 0, m, e, 1'($urandom),
                 $urandom_range(0, 2) != 0, acc);
        end
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            step(1'b0, 24'd0, 8'd0, 1'b0, 1'b1, acc);
            budget++;
        end
        chk("final_drain", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
